// File: rtl/fpu_cvt_wb_pkg.sv
// Shared constants for the float-to-int converter writeback collector.
// Supplies default widths for the codebase's REGIDX_WIDTH/REGEXT_WIDTH/DEPTH_WARP macros.
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 2
`endif

package fpu_cvt_wb_pkg;
  localparam int FFLAG_NV       = 4;
  localparam int FFLAG_DZ       = 3;
  localparam int FFLAG_OF       = 2;
  localparam int FFLAG_UF       = 1;
  localparam int FFLAG_NX       = 0;
  localparam int FFLAGS_W       = 5;
  localparam int LANE_RES_W     = 32;
  localparam int LANE_IN_STRIDE = 64;

  typedef logic [FFLAGS_W-1:0] fflags_t;

  // Flags of an inactive lane must never reach the reduced result.
  function automatic fflags_t lane_flags(input fflags_t flags, input logic active);
    return active ? flags : 5'd0;
  endfunction
endpackage

// File: rtl/fpu_cvt_wb_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head word is read combinationally.
module fpu_cvt_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; writes are refused when full, reads when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; contents are don't-care until written, empty gates the reader.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/fpu_cvt_wb_collector.sv
// Packs converter lane results into a warp writeback word and queues it for the arbiter.
// Optional FPU_CVT_BYPASS_EN: zero-latency pass-through when the queue is empty and the arbiter is ready.
module fpu_cvt_wb_collector
  import fpu_cvt_wb_pkg::*;
#(
  parameter int NUM_THREAD = 4,
  parameter int DEPTH      = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic [NUM_THREAD*LANE_IN_STRIDE-1:0]     result_i,
  input  logic [NUM_THREAD*FFLAGS_W-1:0]           fflags_i,
  input  logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0]   ctrl_regindex_i,
  input  logic [`DEPTH_WARP-1:0]                   ctrl_warpid_i,
  input  logic [NUM_THREAD-1:0]                    ctrl_vecmask_i,
  input  logic                                     ctrl_wvd_i,
  input  logic                                     ctrl_wxd_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [NUM_THREAD*LANE_RES_W-1:0]         wb_data_o,
  output logic [NUM_THREAD-1:0]                    wb_mask_o,
  output logic [FFLAGS_W-1:0]                      fflags_o,
  output logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0]   ctrl_regindex_o,
  output logic [`DEPTH_WARP-1:0]                   ctrl_warpid_o,
  output logic                                     ctrl_wvd_o,
  output logic                                     ctrl_wxd_o
);
  localparam int RI_W   = `REGIDX_WIDTH + `REGEXT_WIDTH;
  localparam int WID_W  = `DEPTH_WARP;
  localparam int DATA_W = NUM_THREAD * LANE_RES_W;
  localparam int ENT_W  = DATA_W + NUM_THREAD + FFLAGS_W + RI_W + WID_W + 2;

  logic [DATA_W-1:0]     pk_data_s;
  logic [NUM_THREAD-1:0] pk_mask_s;
  fflags_t               pk_flags_s;
  logic                  found_s;
  logic [ENT_W-1:0]      wdata_s;
  logic [ENT_W-1:0]      head_s;
  logic [ENT_W-1:0]      out_ent_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  unused_s;

  // Upper 32 bits of each 64-bit lane slot carry no integer result.
  assign unused_s = ^result_i;

  // Lane packing: vector ops keep lane positions, scalar ops take the lowest active lane.
  always_comb begin
    pk_data_s  = {DATA_W{1'b0}};
    pk_flags_s = 5'd0;
    found_s    = 1'b0;
    for (int i = 0; i < NUM_THREAD; i++) begin
      pk_flags_s = pk_flags_s | lane_flags(fflags_i[i*FFLAGS_W +: FFLAGS_W], ctrl_vecmask_i[i]);
      if (ctrl_wxd_i) begin
        if (ctrl_vecmask_i[i] && !found_s) begin
          pk_data_s[LANE_RES_W-1:0] = result_i[i*LANE_IN_STRIDE +: LANE_RES_W];
          found_s                   = 1'b1;
        end else begin
          found_s = found_s;
        end
      end else begin
        pk_data_s[i*LANE_RES_W +: LANE_RES_W] = result_i[i*LANE_IN_STRIDE +: LANE_RES_W];
      end
    end
    pk_mask_s = ctrl_wxd_i ? {{(NUM_THREAD-1){1'b0}}, found_s} : ctrl_vecmask_i;
  end

  assign wdata_s    = {pk_data_s, pk_mask_s, pk_flags_s, ctrl_regindex_i, ctrl_warpid_i,
                       ctrl_wvd_i, ctrl_wxd_i};
  assign in_ready_o = !fifo_full_s;
  assign pop_s      = out_ready_i && !fifo_empty_s;

`ifdef FPU_CVT_BYPASS_EN
  logic byp_s;
  assign byp_s  = fifo_empty_s && in_valid_i && out_ready_i;
  assign push_s = in_valid_i && !fifo_full_s && !byp_s;
`else
  assign push_s = in_valid_i && !fifo_full_s;
`endif

  fpu_cvt_wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Output select: queue head, else the bypassed op, else all-zero while idle.
  always_comb begin
    out_ent_s = {ENT_W{1'b0}};
`ifdef FPU_CVT_BYPASS_EN
    if (!fifo_empty_s) begin
      out_ent_s = head_s;
    end else if (byp_s) begin
      out_ent_s = wdata_s;
    end else begin
      out_ent_s = {ENT_W{1'b0}};
    end
    out_valid_o = !fifo_empty_s || byp_s;
`else
    if (!fifo_empty_s) begin
      out_ent_s = head_s;
    end else begin
      out_ent_s = {ENT_W{1'b0}};
    end
    out_valid_o = !fifo_empty_s;
`endif
  end

  assign {wb_data_o, wb_mask_o, fflags_o, ctrl_regindex_o, ctrl_warpid_o,
          ctrl_wvd_o, ctrl_wxd_o} = out_ent_s;
endmodule

// File: tb/tb_fpu_cvt_wb_collector.sv
// Scoreboard bench for fpu_cvt_wb_collector; bypass scenario runs when FPU_CVT_BYPASS_EN is defined.
`timescale 1ns/1ps
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 2
`endif

module tb_fpu_cvt_wb_collector;
  localparam int NT = 4;
  localparam int RI = `REGIDX_WIDTH + `REGEXT_WIDTH;
  localparam int WI = `DEPTH_WARP;
  localparam int EW = NT*32 + NT + 5 + RI + WI + 2;
`ifdef FPU_CVT_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef logic [EW-1:0] ent_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NT*64-1:0] result = '0;
  logic [NT*5-1:0] fflags = '0;
  logic [RI-1:0]   regidx = '0;
  logic [WI-1:0]   warpid = '0;
  logic [NT-1:0]   vecmask = '0;
  logic            wvd = 1'b0;
  logic            wxd = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NT*32-1:0] wb_data;
  logic [NT-1:0]   wb_mask;
  logic [4:0]      fflags_out;
  logic [RI-1:0]   regidx_out;
  logic [WI-1:0]   warpid_out;
  logic            wvd_out;
  logic            wxd_out;
  ent_t            obs;
  ent_t            sb[$];
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  fpu_cvt_wb_collector #(.NUM_THREAD(NT), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .result_i(result), .fflags_i(fflags), .ctrl_regindex_i(regidx), .ctrl_warpid_i(warpid),
    .ctrl_vecmask_i(vecmask), .ctrl_wvd_i(wvd), .ctrl_wxd_i(wxd),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .wb_data_o(wb_data), .wb_mask_o(wb_mask),
    .fflags_o(fflags_out), .ctrl_regindex_o(regidx_out), .ctrl_warpid_o(warpid_out),
    .ctrl_wvd_o(wvd_out), .ctrl_wxd_o(wxd_out)
  );

  assign obs = {wb_data, wb_mask, fflags_out, regidx_out, warpid_out, wvd_out, wxd_out};

  // Reference packing of the currently driven inputs.
  function automatic ent_t model();
    logic [NT*32-1:0] d = '0;
    logic [NT-1:0]    m = 4'b0000;
    logic [4:0]       f = 5'd0;
    int               sel = -1;
    for (int i = 0; i < NT; i++) begin
      if (vecmask[i]) begin
        f = f | fflags[5*i +: 5];
        if (sel < 0) sel = i;
      end
    end
    if (!wxd) begin
      for (int i = 0; i < NT; i++) d[32*i +: 32] = result[64*i +: 32];
      m = vecmask;
    end else if (sel >= 0) begin
      d[31:0] = result[64*sel +: 32];
      m = 4'b0001;
    end
    return {d, m, f, regidx, warpid, wvd, wxd};
  endfunction

  task automatic rand_op(input int tag);
    for (int i = 0; i < NT*2; i++) result[32*i +: 32] = $urandom;
    fflags  = NT*5'($urandom);
    vecmask = 4'($urandom_range(0, 15));
    wxd     = 1'($urandom_range(0, 1));
    wvd     = !wxd;
    warpid  = WI'($urandom);
    regidx  = RI'(tag);
  endtask

  task automatic sample_push();
    if (in_valid && in_ready) sb.push_back(model());
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    #4 rst_n = 1'b1;
    next_cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_vector();
    ent_t exp;
    result = '0;
    result[0 +: 32] = 32'd1;   result[32 +: 32] = 32'hDEADBEEF;
    result[64 +: 32] = 32'd2;  result[96 +: 32] = 32'hCAFEF00D;
    result[128 +: 32] = 32'd3; result[192 +: 32] = 32'd4;
    fflags = '0; fflags[5] = 1'b1; fflags[14] = 1'b1;
    vecmask = 4'b1011; wxd = 1'b0; wvd = 1'b1; regidx = RI'(7); warpid = WI'(1);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c < 2) begin
        total++;
        if (out_valid !== ((c == 0) ? BYP : !BYP)) begin
          bad++; $display("FAIL vec_latency: cycle %0d got %b", c, out_valid);
        end
      end
      if (out_valid) begin
        total++;
        if ({wb_data, wb_mask, fflags_out} !== {32'd4, 32'd3, 32'd2, 32'd1, 4'b1011, 5'b00001}) begin
          bad++; $display("FAIL vec_pack: got %h/%b/%b want 4,3,2,1/1011/00001", wb_data, wb_mask, fflags_out);
        end
      end
      sample_push();
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL vec_sb: unexpected %h", obs); end
        else begin exp = sb.pop_front(); if (obs !== exp) begin bad++; $display("FAIL vec_sb: got %h want %h", obs, exp); end end
      end
      next_cycle();
      in_valid = 1'b0;
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL vec_drain: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_scalar();
    ent_t exp;
    int   seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 3);
      wxd = 1'b1; wvd = 1'b0; warpid = WI'(2);
      for (int i = 0; i < NT*2; i++) result[32*i +: 32] = 32'h11111111 * (i + 1);
      fflags = 20'hFFFFF;
      if (c == 0) begin vecmask = 4'b0100; result[128 +: 32] = 32'hFFFFFFFF; regidx = RI'(20); end
      else if (c == 1) begin vecmask = 4'b0000; regidx = RI'(21); end
      else begin vecmask = 4'b0110; regidx = RI'(22); end
      @(negedge clk);
      sample_push();
      if (out_valid && out_ready) begin
        if (regidx_out == RI'(20)) begin
          seen++; total++;
          if ({wb_data, wb_mask} !== {96'd0, 32'hFFFFFFFF, 4'b0001}) begin
            bad++; $display("FAIL scalar_pack: got %h/%b want lane0 ffffffff/0001", wb_data, wb_mask);
          end
        end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL scalar_sb: unexpected %h", obs); end
        else begin exp = sb.pop_front(); if (obs !== exp) begin bad++; $display("FAIL scalar_sb: got %h want %h", obs, exp); end end
      end
      next_cycle();
      in_valid = 1'b0;
      if (c >= 3 && sb.size() == 0) break;
    end
    total++; if (seen != 1 || sb.size() != 0) begin bad++; $display("FAIL scalar_done: seen %0d left %0d want 1/0", seen, sb.size()); end
  endtask

  task automatic test_full();
    ent_t exp;
    int   k = 0;
    logic want;
    for (int c = 0; c < 30; c++) begin
      in_valid = (k < 5);
      rand_op(30 + k);
      out_ready = (c >= 5);
      @(negedge clk);
      if (c <= 6) begin
        want = (c < 4) || (c == 6);
        total++;
        if (in_ready !== want) begin bad++; $display("FAIL full_ready: cycle %0d got %b want %b", c, in_ready, want); end
      end
      sample_push();
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL full_sb: unexpected %h", obs); end
        else begin exp = sb.pop_front(); if (obs !== exp) begin bad++; $display("FAIL full_sb: got %h want %h", obs, exp); end end
      end
      next_cycle();
      if (k == 5 && sb.size() == 0) break;
    end
    in_valid = 1'b0;
    total++; if (k != 5 || sb.size() != 0) begin bad++; $display("FAIL full_done: sent %0d left %0d want 5/0", k, sb.size()); end
  endtask

  task automatic test_stream();
    ent_t exp;
    int   k = 0;
    logic want;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (k < 16);
      rand_op(k);
      @(negedge clk);
      if (c < 16) begin
        want = (c == 0) ? BYP : 1'b1;
        total++;
        if ({in_ready, out_valid} !== {1'b1, want}) begin
          bad++; $display("FAIL stream_rate: cycle %0d got rdy %b vld %b want 1 %b", c, in_ready, out_valid, want);
        end
      end
      sample_push();
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL stream_sb: unexpected %h", obs); end
        else begin exp = sb.pop_front(); if (obs !== exp) begin bad++; $display("FAIL stream_sb: got %h want %h", obs, exp); end end
      end
      next_cycle();
      if (k == 16 && sb.size() == 0) break;
    end
    in_valid = 1'b0;
    total++; if (k != 16 || sb.size() != 0) begin bad++; $display("FAIL stream_done: sent %0d left %0d want 16/0", k, sb.size()); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      rand_op(40 + c);
      @(negedge clk);
      sample_push();
      next_cycle();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_queued: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL arst_flags: got vld %b rdy %b want 0 1", out_valid, in_ready); end
    total++; if (obs !== '0) begin bad++; $display("FAIL arst_outputs: got %h want 0", obs); end
    sb.delete();
    #3 rst_n = 1'b1;
    next_cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_after: got %b want 0", out_valid); end
  endtask

`ifdef FPU_CVT_BYPASS_EN
  task automatic test_bypass();
    ent_t exp;
    out_ready = 1'b1; in_valid = 1'b1;
    rand_op(50);
    @(negedge clk);
    exp = model();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL byp_valid: got %b want 1", out_valid); end
    total++; if (obs !== exp) begin bad++; $display("FAIL byp_data: got %h want %h", obs, exp); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL byp_empty: got %b want 0", out_valid); end
    next_cycle();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_op(51);
    @(negedge clk);
    exp = model();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL byp_hold_now: got %b want 0", out_valid); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || obs !== exp) begin bad++; $display("FAIL byp_hold_next: got %b %h want 1 %h", out_valid, obs, exp); end
    out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL byp_drained: got %b want 0", out_valid); end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_vector();
    test_scalar();
    test_full();
    test_stream();
    test_async_reset();
`ifdef FPU_CVT_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
